// File: rtl/mbist_march_engine.sv
// mbist_march_engine
//   Memory BIST controller running March Y or March C- over a 2**AW x DW
//   single-port memory, using a programmable data background. It records
//   the first failing read and keeps a saturating count of all miscompares.
// Ports
//   clk, rst (sync, active-low)   clock and reset
//   start, alg_sel, bg_pattern    test request; algorithm and background are
//                                 sampled together with an accepted start
//   busy, done, pass              handshake and overall result
//   mem_addr/we/re/wdata/rdata    direct drive of the memory macro port
//   fail_valid/addr/elem/exp/act  first miscompare record (sticky)
//   fail_cnt                      total miscompares, saturating
module mbist_march_engine #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int RD_LAT = 1,
  parameter int FCW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          alg_sel,
  input  logic [DW-1:0] bg_pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          fail_valid,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_act,
  output logic [FCW-1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  // Number of operations applied at each address of an element.
  function automatic logic [1:0] elem_len(input logic alg, input logic [2:0] e);
    if (!alg) return (e == 3'd1 || e == 3'd2) ? 2'd3 : 2'd1;
    else      return (e == 3'd0 || e == 3'd5) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic elem_down(input logic alg, input logic [2:0] e);
    if (!alg) return (e == 3'd2);
    else      return (e == 3'd3 || e == 3'd4);
  endfunction

  // Returns {is_write, uses_inverted_background}.
  function automatic logic [1:0] op_kind(input logic alg, input logic [2:0] e,
                                         input logic [1:0] o);
    logic [1:0] k;
    k = 2'b00;
    if (e == 3'd0) begin
      k = 2'b10;
    end else if (!alg) begin
      // E1 = r0,w1,r1 ; E2 = r1,w0,r0 ; E3 = r0
      case (o)
        2'd0:    k = (e == 3'd2) ? 2'b01 : 2'b00;
        2'd1:    k = (e == 3'd1) ? 2'b11 : 2'b10;
        default: k = (e == 3'd1) ? 2'b01 : 2'b00;
      endcase
    end else begin
      // Odd elements r0,w1 ; even elements r1,w0 ; final element r0
      if (e == 3'd5)  k = 2'b00;
      else if (e[0])  k = (o == 2'd0) ? 2'b00 : 2'b11;
      else            k = (o == 2'd0) ? 2'b01 : 2'b10;
    end
    return k;
  endfunction

  logic          alg_reg;
  logic [DW-1:0] bg_reg;
  logic [2:0]    elem_reg;
  logic [1:0]    op_reg;
  logic [AW-1:0] addr_reg;
  logic          seq_end_reg;
  logic [2:0]    drain_cnt_reg;
  logic [2:0]    bus_elem_reg;
  logic [DW-1:0] bus_exp_reg;

  logic          accept, issue, iss_alg, iss_down, addr_end, end_next;
  logic [DW-1:0] iss_bg, iss_data;
  logic [2:0]    iss_elem, last_elem, pos_elem_next;
  logic [1:0]    iss_op, iss_len, iss_kind, pos_op_next;
  logic [AW-1:0] iss_addr, pos_addr_next;

  // The op issued at the accepting edge comes straight from the inputs so
  // that it reaches the bus in the very next cycle.
  always_comb begin
    accept    = start && (state_reg == IDLE || state_reg == DONE);
    issue     = accept || (state_reg == RUN && !seq_end_reg);
    iss_alg   = accept ? alg_sel    : alg_reg;
    iss_bg    = accept ? bg_pattern : bg_reg;
    iss_elem  = accept ? 3'd0       : elem_reg;
    iss_op    = accept ? 2'd0       : op_reg;
    iss_addr  = accept ? '0         : addr_reg;
    iss_len   = elem_len(iss_alg, iss_elem);
    iss_down  = elem_down(iss_alg, iss_elem);
    iss_kind  = op_kind(iss_alg, iss_elem, iss_op);
    iss_data  = iss_kind[0] ? ~iss_bg : iss_bg;
    last_elem = iss_alg ? 3'd5 : 3'd3;
    addr_end  = iss_down ? (iss_addr == '0) : (iss_addr == '1);

    pos_elem_next = iss_elem;
    pos_op_next   = iss_op + 2'd1;
    pos_addr_next = iss_addr;
    end_next      = 1'b0;
    if (iss_op == iss_len - 2'd1) begin
      pos_op_next = 2'd0;
      if (addr_end) begin
        if (iss_elem == last_elem) begin
          end_next = 1'b1;
        end else begin
          pos_elem_next = iss_elem + 3'd1;
          pos_addr_next = elem_down(iss_alg, iss_elem + 3'd1) ? '1 : '0;
        end
      end else begin
        pos_addr_next = iss_down ? iss_addr - AW'(1) : iss_addr + AW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (accept) state_next = RUN;
      RUN:        if (seq_end_reg) state_next = DRAIN;
      DRAIN:      if (drain_cnt_reg == 3'(RD_LAT)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      alg_reg       <= 1'b0;
      bg_reg        <= '0;
      elem_reg      <= 3'd0;
      op_reg        <= 2'd0;
      addr_reg      <= '0;
      seq_end_reg   <= 1'b0;
      drain_cnt_reg <= 3'd0;
      bus_elem_reg  <= 3'd0;
      bus_exp_reg   <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 3'd1 : 3'd0;
      if (accept) begin
        alg_reg <= alg_sel;
        bg_reg  <= bg_pattern;
      end
      if (issue) begin
        mem_we       <= iss_kind[1];
        mem_re       <= ~iss_kind[1];
        mem_addr     <= iss_addr;
        if (iss_kind[1]) mem_wdata <= iss_data;
        bus_elem_reg <= iss_elem;
        bus_exp_reg  <= iss_data;
        elem_reg     <= pos_elem_next;
        op_reg       <= pos_op_next;
        addr_reg     <= pos_addr_next;
        seq_end_reg  <= end_next;
      end else begin
        mem_we <= 1'b0;
        mem_re <= 1'b0;
      end
    end
  end

  // Read tag pipeline: stage RD_LAT-1 lines up with valid mem_rdata.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
    logic          vld;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [DW-1:0] xdata;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst) begin
          vld <= 1'b0; addr <= '0; elem <= 3'd0; xdata <= '0;
        end else begin
          vld <= mem_re; addr <= mem_addr; elem <= bus_elem_reg; xdata <= bus_exp_reg;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst) begin
          vld <= 1'b0; addr <= '0; elem <= 3'd0; xdata <= '0;
        end else begin
          vld   <= g_stage[gi-1].vld;
          addr  <= g_stage[gi-1].addr;
          elem  <= g_stage[gi-1].elem;
          xdata <= g_stage[gi-1].xdata;
        end
      end
    end
  end

  logic cmp_fail;
  assign cmp_fail = g_stage[RD_LAT-1].vld && (mem_rdata != g_stage[RD_LAT-1].xdata);

  always_ff @(posedge clk) begin
    if (!rst || accept) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_exp   <= '0;
      fail_act   <= '0;
      fail_cnt   <= '0;
    end else if (cmp_fail) begin
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_addr  <= g_stage[RD_LAT-1].addr;
        fail_elem  <= g_stage[RD_LAT-1].elem;
        fail_exp   <= g_stage[RD_LAT-1].xdata;
        fail_act   <= mem_rdata;
      end
      if (fail_cnt != '1) fail_cnt <= fail_cnt + FCW'(1);
    end
  end

  assign busy = (state_reg == RUN) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);
  assign pass = done && !fail_valid;

endmodule
